// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// LSB digit first, with valid/ready handshakes on both sides.
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub_unit: WIDTH must be >= 2 and an exact multiple of DIGIT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] a_dig_c;
  logic [DIGIT-1:0] b_dig_c;
  logic [DIGIT-1:0] s_dig_c;
  logic [DIGIT:0]   c_c;
  logic [WIDTH-1:0] sum_d;
  logic             last_c;

  // Select the current digit of each operand.
  always_comb begin
    a_dig_c = '0;
    b_dig_c = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig_c = a_q[i*DIGIT +: DIGIT];
        b_dig_c = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // DIGIT-bit ripple slice fed by the carry register.
  always_comb begin
    s_dig_c = '0;
    c_c     = '0;
    c_c[0]  = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_dig_c[i] = a_dig_c[i] ^ b_dig_c[i] ^ c_c[i];
      c_c[i+1]   = (a_dig_c[i] & b_dig_c[i]) | (c_c[i] & (a_dig_c[i] ^ b_dig_c[i]));
    end
  end

  // Merge the fresh digit into the partial result.
  always_comb begin
    sum_d = sum_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) begin
        sum_d[i*DIGIT +: DIGIT] = s_dig_c;
      end
    end
  end

  assign last_c = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + ~cin, so invert b and the incoming carry here.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= cin ^ sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= c_c[DIGIT];
          if (last_c) begin
            cout_q      <= c_c[DIGIT];
            ovf_q       <= c_c[DIGIT] ^ c_c[DIGIT-1];
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Multi-cycle, parametrised adder/subtractor. Next generation of the team's 4-bit ripple-carry full-adder block.
- Processes operands DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple slice. Carry is held in a register between cycles.
- Adds a real subtract mode with borrow-in, signed overflow and zero flags, and valid/ready handshakes on input and output.
- Sits between an operand source and a result consumer in datapath blocks that need WIDTH-bit add/sub without a full-width ripple chain.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be at least 2.
- DIGIT, 2: bits processed per cycle. Must be at least 1 and divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = add, 1 = subtract
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  add: carry-out; sub: 1 = no borrow, 0 = borrow
- ovf  out  1  signed (two's complement) overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-operation:
  - state goes to IDLE;
  - sum, cout, ovf, zero and out_valid go to 0;
  - the in-progress operation is discarded, with no partial result.
  - in_ready is 1 in the first cycle after reset.
- Arithmetic, fixed for both modes:
  - ADD: {cout, sum} = a + b + cin.
  - SUB: {cout, sum} = a + ~b + ~cin, i.e. a - b - cin with cout = NOT borrow.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
  - Results are modulo 2^WIDTH; no saturation.
- States:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, the edge latches a, b (inverted if sub), sub, and the initial carry (cin, or ~cin if sub). Digit counter clears to 0. Go to RUN.
  - RUN: in_ready=0. Each edge computes digit d = counter, writes sum bits [d*DIGIT +: DIGIT] and updates the carry register. On the MSB digit (counter = WIDTH/DIGIT - 1), also latch cout, ovf and zero, then go to DONE. Otherwise counter increments.
  - DONE: out_valid=1, in_ready=0. sum, cout, ovf and zero are stable. When out_ready=1, go to IDLE on that edge.
- Latency:
  - Operand accept edge at cycle k; out_valid is first high in cycle k + WIDTH/DIGIT + 1.
  - Minimum initiation interval is WIDTH/DIGIT + 2 cycles.
  - No same-cycle result-drain and operand-accept.
- Operands and inputs:
  - a, b, sub and cin are sampled only on the accept edge. Changes during RUN/DONE are ignored.
  - in_valid during RUN/DONE is ignored; the source must hold it until in_ready.
- Result holding:
  - out_ready while not in DONE is ignored.
  - The result is held indefinitely while out_ready=0 (backpressure).
  - After a drain, sum/flags keep their last value; only out_valid drops.
- DIGIT = WIDTH: single RUN cycle, so latency is 2 cycles from accept.
- DIGIT = 1: fully bit-serial, latency WIDTH+1.

Test Plan:
- WIDTH=8, DIGIT=2, add: a=200, b=100, cin=0 -> sum=44, cout=1, ovf=0, zero=0. out_valid exactly 5 cycles after the accept edge.
- Subtract, no borrow: a=12, b=8, sub=1, cin=0 -> sum=4, cout=1, ovf=0. Then a=3, b=5, sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0.
- Signed overflow: a=127, b=1, add -> sum=0x80, ovf=1, cout=0. Then a=0x80, b=1, sub -> sum=0x7F, ovf=1, cout=1.
- Borrow-in and zero: a=10, b=3, sub=1, cin=1 -> sum=6, cout=1. Then a=0, b=0, add, cin=0 -> sum=0, zero=1.
- Handshake:
  - Hold out_ready=0 for 7 cycles: result and out_valid stay stable, and in_ready=0 throughout, even with in_valid=1.
  - Then assert out_ready=1: IDLE next cycle, and a second operation is accepted and completes correctly.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle all outputs 0 and in_ready=1. A fresh 255+1 gives sum=0, cout=1, zero=1. Repeat the 200+100 case with DIGIT=1 (latency 9) and DIGIT=8 (latency 2).
